// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the two-port main-memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE
  } mem_state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int MEM_DEPTH_LOG2 = 9;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; req[0] is the fetch port, req[1] the data port.
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_reg;

  // On a tie the port not granted last wins; a lone request wins outright.
  always_comb begin
    gnt_valid = en & (req[0] | req[1]);
    if (req[0] & req[1]) begin
      gnt_id = ~last_reg;
    end else begin
      gnt_id = req[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= PORT_FETCH;
    end else if (update) begin
      last_reg <= gnt_id;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports,
// sequencing SETUP/STROBE/RELEASE so address and data are stable around strobes.
module mem_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_mdatain,
  input  logic [DATA_W-1:0] ram_q
);

  mem_state_t        state_reg, state_next;
  logic              port_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic              arb_en;
  logic              gnt_valid;
  logic              gnt_id;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              in_range;

  // The port being acked this cycle sits out this arbitration round.
  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (arb_en),
    .req       ({d_req & ~d_ack, f_req & ~f_ack}),
    .update    (gnt_valid),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    arb_en     = (state_reg == IDLE) || (state_reg == RELEASE);
    sel_addr   = (gnt_id == PORT_DATA) ? d_addr : f_addr;
    sel_we     = (gnt_id == PORT_DATA) ? d_we : 1'b0;
    in_range   = (sel_addr >> DEPTH_LOG2) == '0;
    state_next = state_reg;
    case (state_reg)
      IDLE, RELEASE: begin
        if (gnt_valid) begin
          state_next = in_range ? SETUP : RELEASE;
        end else begin
          state_next = IDLE;
        end
      end
      SETUP:   state_next = STROBE;
      STROBE:  state_next = RELEASE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign ram_read    = (state_reg == STROBE) & ~we_reg;
  assign ram_write   = (state_reg == STROBE) & we_reg;
  assign ram_address = addr_reg;
  assign ram_mdatain = wdata_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      port_reg  <= PORT_FETCH;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      f_ack     <= 1'b0;
      f_err     <= 1'b0;
      f_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      state_reg <= state_next;
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
      if (gnt_valid) begin
        port_reg <= gnt_id;
        if (in_range) begin
          addr_reg  <= sel_addr;
          we_reg    <= sel_we;
          wdata_reg <= d_wdata;
        end else if (gnt_id == PORT_DATA) begin
          // Out-of-range never touches the memory address lines.
          d_ack   <= 1'b1;
          d_err   <= 1'b1;
          d_rdata <= '0;
        end else begin
          f_ack   <= 1'b1;
          f_err   <= 1'b1;
          f_rdata <= '0;
        end
      end
      if (state_reg == STROBE) begin
        if (port_reg == PORT_DATA) begin
          d_ack   <= 1'b1;
          d_err   <= 1'b0;
          d_rdata <= we_reg ? '0 : ram_q;
        end else begin
          f_ack   <= 1'b1;
          f_err   <= 1'b0;
          f_rdata <= ram_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and an ack scoreboard.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ack;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] ram_address;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_mdatain;
  logic [31:0] ram_q;

  logic        pre_we;
  logic [8:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [0:511];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .f_req       (f_req),
    .f_addr      (f_addr),
    .f_ack       (f_ack),
    .f_rdata     (f_rdata),
    .f_err       (f_err),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .d_err       (d_err),
    .ram_address (ram_address),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_mdatain (ram_mdatain),
    .ram_q       (ram_q)
  );

  assign ram_q = mem[ram_address[8:0]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_write) mem[ram_address[8:0]] <= ram_mdatain;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] v);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic push(input logic port, input logic [31:0] rd, input logic err,
                      input int lat, input int nrd, input int nwr);
    exp_t e;
    e.port = port; e.rdata = rd; e.err = err; e.lat = lat; e.nrd = nrd; e.nwr = nwr;
    sb.push_back(e);
  endtask

  // Waits for the next ack (bounded), tracking strobe behaviour on the way.
  task automatic wait_ack(input string tag, input int n0);
    int n = n0;
    int nrd = 0, nwr = 0, nboth = 0, nmove = 0, stb_at = -1;
    logic got = 1'b0;
    logic [31:0] prev = ram_address;
    exp_t e;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ram_read) nrd++;
      if (ram_write) nwr++;
      if (ram_read && ram_write) nboth++;
      if ((ram_read || ram_write) && ram_address !== prev) nmove++;
      if ((ram_read || ram_write) && stb_at < 0) stb_at = n;
      prev = ram_address;
      got = f_ack | d_ack;
    end
    if (!got) begin
      chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_ack"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_port"}, {31'd0, d_ack}, {31'd0, e.port});
    chk({tag, "_dual_ack"}, {31'd0, f_ack & d_ack}, 32'd0);
    chk({tag, "_rdata"}, e.port ? d_rdata : f_rdata, e.rdata);
    chk({tag, "_err"}, {31'd0, e.port ? d_err : f_err}, {31'd0, e.err});
    chk({tag, "_latency"}, 32'(n), 32'(e.lat));
    chk({tag, "_nread"}, 32'(nrd), 32'(e.nrd));
    chk({tag, "_nwrite"}, 32'(nwr), 32'(e.nwr));
    chk({tag, "_both_strobes"}, 32'(nboth), 32'd0);
    chk({tag, "_addr_move"}, 32'(nmove), 32'd0);
    if (e.nrd + e.nwr > 0) chk({tag, "_strobe_cycle"}, 32'(stb_at), 32'(e.lat - 1));
  endtask

  initial begin
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    preload(9'h000, 32'h01000095);
    preload(9'h095, 32'h12345678);
    preload(9'h1FF, 32'h00C0FFEE);
    @(posedge clk); #1;

    chk("rst_ram_read", {31'd0, ram_read}, 32'd0);
    chk("rst_ram_write", {31'd0, ram_write}, 32'd0);
    chk("rst_ram_address", ram_address, 32'd0);
    chk("rst_ram_mdatain", ram_mdatain, 32'd0);
    chk("rst_acks", {30'd0, f_ack, d_ack}, 32'd0);
    chk("rst_errs", {30'd0, f_err, d_err}, 32'd0);
    chk("rst_f_rdata", f_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both ports held from reset: data wins the first tie, then alternation.
    f_req = 1'b1; f_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h95;
    push(1'b1, 32'h12345678, 1'b0, 3, 1, 0);
    push(1'b0, 32'h01000095, 1'b0, 3, 1, 0);
    push(1'b1, 32'h12345678, 1'b0, 3, 1, 0);
    push(1'b0, 32'h01000095, 1'b0, 3, 1, 0);
    wait_ack("rr1_d", 0);
    wait_ack("rr2_f", 0);
    wait_ack("rr3_d", 0);
    wait_ack("rr4_f", 0);
    f_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single fetch of word 0.
    f_req = 1'b1; f_addr = 32'h0;
    push(1'b0, 32'h01000095, 1'b0, 3, 1, 0);
    wait_ack("fetch0", 0);
    f_req = 1'b0;
    @(posedge clk); #1;

    // Write 0x95; inputs scrambled after grant must be ignored.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h95; d_wdata = 32'hAAAAAAAA;
    push(1'b1, 32'h0, 1'b0, 3, 0, 1);
    @(posedge clk); #1;
    d_addr = 32'h33; d_wdata = 32'h0; d_we = 1'b0;
    wait_ack("write95", 1);
    d_req = 1'b0;
    chk("f_rdata_hold", f_rdata, 32'h01000095);
    f_req = 1'b1; f_addr = 32'h95;
    push(1'b0, 32'hAAAAAAAA, 1'b0, 3, 1, 0);
    wait_ack("readback95", 0);
    f_req = 1'b0;
    @(posedge clk); #1;

    // Out-of-range data read, then the top in-range word.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    push(1'b1, 32'h0, 1'b1, 1, 0, 0);
    wait_ack("oor200", 0);
    d_addr = 32'h1FF;
    @(posedge clk); #1;
    chk("oor_err_hold", {31'd0, d_err}, 32'd1);
    push(1'b1, 32'h00C0FFEE, 1'b0, 3, 1, 0);
    wait_ack("top1ff", 0);
    d_req = 1'b0;
    @(posedge clk); #1;

    // Reset asserted while a write is strobing.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h5555AAAA;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_strobe_write", {31'd0, ram_write}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_write_drop", {31'd0, ram_write}, 32'd0);
    chk("async_read_drop", {31'd0, ram_read}, 32'd0);
    d_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_ack_in_reset", {30'd0, f_ack, d_ack}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h0;
    push(1'b0, 32'h01000095, 1'b0, 3, 1, 0);
    wait_ack("after_reset", 0);
    f_req = 1'b0;
    @(posedge clk); #1;

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
